// File: rtl/mc_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mc_datapath
// Description : Multicycle RV32 datapath (LW, SW, ADDI, ADD/SUB/AND/OR, BEQ)
//               with PC/OLDPC/IR/MDR/A/B/ALUOUT, 32x32 register file and ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic        ALUSrcA,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        PCSource,
  input  logic [1:0]  ALUSrcB,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] pc_out
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_OR  = 4'b0001;
  localparam logic [3:0] c_ALU_ADD = 4'b0010;
  localparam logic [3:0] c_ALU_SUB = 4'b0110;

  logic [31:0] r_pc;
  logic [31:0] r_oldpc;
  logic [31:0] r_ir;
  logic [31:0] r_mdr;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_aluout;
  logic [31:0] r_rf [0:31];

  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [31:0] w_imm;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_result;
  logic        w_zero;
  logic        w_pc_load;

  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_rd  = r_ir[11:7];

  assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];

  always_comb begin
    w_imm = 32'd0;
    case (r_ir[6:0])
      c_OP_LOAD, c_OP_IMM: w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
      c_OP_STORE:          w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      c_OP_BRANCH:         w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      default:             w_imm = 32'd0;
    endcase
  end

  // OLDPC feeds the ALU outside fetch so decode computes the branch target
  always_comb begin
    w_alu_a = r_oldpc;
    if (ALUSrcA) begin
      w_alu_a = r_a;
    end else if (IRWrite) begin
      w_alu_a = r_pc;
    end
  end

  always_comb begin
    w_alu_b = r_b;
    case (ALUSrcB)
      2'b00:   w_alu_b = r_b;
      2'b01:   w_alu_b = 32'd4;
      default: w_alu_b = w_imm;
    endcase
  end

  always_comb begin
    w_alu_result = 32'd0;
    case (alu_ctrl)
      c_ALU_ADD: w_alu_result = w_alu_a + w_alu_b;
      c_ALU_SUB: w_alu_result = w_alu_a - w_alu_b;
      c_ALU_AND: w_alu_result = w_alu_a & w_alu_b;
      c_ALU_OR:  w_alu_result = w_alu_a | w_alu_b;
      default:   w_alu_result = 32'd0;
    endcase
  end

  assign w_zero    = (w_alu_result == 32'd0);
  assign w_pc_load = PCWrite | (PCWriteCond & w_zero);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_oldpc  <= 32'd0;
      r_ir     <= 32'd0;
      r_mdr    <= 32'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_aluout <= 32'd0;
    end else begin
      r_mdr    <= mem_rdata;
      r_a      <= w_rs1_data;
      r_b      <= w_rs2_data;
      r_aluout <= w_alu_result;
      if (IRWrite) begin
        r_ir    <= mem_rdata;
        r_oldpc <= r_pc;
      end
      if (w_pc_load) begin
        r_pc <= PCSource ? r_aluout : w_alu_result;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= 32'd0;
      end
    end else if (RegWrite && (w_rd != 5'd0)) begin
      r_rf[w_rd] <= MemtoReg ? r_mdr : r_aluout;
    end
  end

  assign mem_addr  = IorD ? r_aluout : r_pc;
  assign mem_wdata = r_b;
  assign mem_read  = MemRead;
  assign mem_write = MemWrite;
  assign opcode    = r_ir[6:0];
  assign funct3    = r_ir[14:12];
  assign funct7    = r_ir[31:25];
  assign pc_out    = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_datapath
// Description : Self-checking bench: directed vector table, corner sequences
//               and random programs checked against an ISA-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_datapath;

  logic        clk;
  logic        reset;
  logic        RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD;
  logic        IRWrite, PCWrite, PCWriteCond, PCSource;
  logic [1:0]  ALUSrcB;
  logic [3:0]  alu_ctrl;
  logic [31:0] mem_rdata, mem_addr, mem_wdata, pc_out;
  logic        mem_read, mem_write;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .alu_ctrl(alu_ctrl),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .pc_out(pc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Unified memory seen by the DUT; ovr lets the bench force an IR value
  logic [31:0] mem [0:255];
  logic        ovr;
  logic [31:0] ovr_data;
  assign mem_rdata = ovr ? ovr_data : mem[mem_addr[9:2]];

  // ISA-level reference state
  logic [31:0] m_x [0:31];
  logic [31:0] m_pc;
  logic [31:0] mm [0:255];

  int tests;
  int fails;

  typedef struct {
    logic [31:0] instr;
    int          rg;
    logic [31:0] val;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl [0:16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] i_type(input int op, input int rd, input int f3, input int rs1, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] r_type(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] s_type(input int rs2, input int rs1, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_type(input int rs1, input int rs2, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'b000, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  task automatic model_exec(input logic [31:0] w);
    logic [31:0] a, b, ii, ib, ea, npc;
    a   = m_x[w[19:15]];
    b   = m_x[w[24:20]];
    ii  = 32'($signed(w) >>> 20);
    ib  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    npc = m_pc + 32'd4;
    case (w[6:0])
      7'h13: m_x[w[11:7]] = a + ii;
      7'h33: begin
        case ({w[30], w[14:12]})
          4'b0000: m_x[w[11:7]] = a + b;
          4'b1000: m_x[w[11:7]] = a - b;
          4'b0111: m_x[w[11:7]] = a & b;
          4'b0110: m_x[w[11:7]] = a | b;
          default: ;
        endcase
      end
      7'h03: begin ea = a + ii; m_x[w[11:7]] = mm[ea[9:2]]; end
      7'h23: begin ea = a + imm_s(w); mm[ea[9:2]] = b; end
      7'h63: if (a == b) npc = m_pc + ib;
      default: ;
    endcase
    m_x[0] = 32'd0;
    m_pc   = npc;
  endtask

  task automatic idle();
    RegWrite = 0; ALUSrcA = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0;
    IorD = 0; IRWrite = 0; PCWrite = 0; PCWriteCond = 0; PCSource = 0;
    ALUSrcB = 2'b00; alu_ctrl = 4'b0010; ovr = 0;
  endtask

  // One clock: stores commit to the bench memory at the edge
  task automatic clk1();
    logic [31:0] a, d;
    logic we;
    a = mem_addr; d = mem_wdata; we = mem_write;
    @(posedge clk);
    if (we) mem[a[9:2]] = d;
    #1;
  endtask

  task automatic fetch();
    idle(); MemRead = 1; IRWrite = 1; ALUSrcB = 2'b01; alu_ctrl = 4'b0010; PCWrite = 1;
    clk1();
  endtask

  task automatic decode();
    idle(); ALUSrcB = 2'b11; alu_ctrl = 4'b0010;
    clk1();
  endtask

  task automatic run_instr(input logic [31:0] w);
    logic [31:0] ea;
    fetch();
    decode();
    case (w[6:0])
      7'h03, 7'h23: begin
        idle(); ALUSrcA = 1; ALUSrcB = 2'b10; alu_ctrl = 4'b0010; clk1();
        if (w[6:0] == 7'h03) begin
          idle(); IorD = 1; MemRead = 1; clk1();
          idle(); RegWrite = 1; MemtoReg = 1; clk1();
        end else begin
          idle(); IorD = 1; MemWrite = 1; #1;
          ea = m_x[w[19:15]] + imm_s(w);
          check("store_addr", mem_addr, ea);
          check("store_data", mem_wdata, m_x[w[24:20]]);
          check("store_we", {31'd0, mem_write}, 32'd1);
          clk1();
        end
      end
      7'h13: begin
        idle(); ALUSrcA = 1; ALUSrcB = 2'b10; alu_ctrl = 4'b0010; clk1();
        idle(); RegWrite = 1; clk1();
      end
      7'h33: begin
        idle(); ALUSrcA = 1; ALUSrcB = 2'b00;
        case ({w[30], w[14:12]})
          4'b1000: alu_ctrl = 4'b0110;
          4'b0111: alu_ctrl = 4'b0000;
          4'b0110: alu_ctrl = 4'b0001;
          default: alu_ctrl = 4'b0010;
        endcase
        clk1();
        idle(); RegWrite = 1; clk1();
      end
      7'h63: begin
        idle(); ALUSrcA = 1; ALUSrcB = 2'b00; alu_ctrl = 4'b0110;
        PCWriteCond = 1; PCSource = 1; clk1();
      end
      default: ;
    endcase
    idle();
  endtask

  task automatic exec_one(input logic [31:0] w);
    mem[m_pc[9:2]] = w;
    mm[m_pc[9:2]]  = w;
    run_instr(w);
    model_exec(w);
  endtask

  // Loads IR with rs2=r, then B (= mem_wdata) holds that register
  task automatic probe(input int r, output logic [31:0] v);
    idle(); ovr = 1; ovr_data = {7'd0, 5'(r), 20'd0}; IRWrite = 1; clk1();
    idle(); clk1();
    v = mem_wdata;
  endtask

  function automatic logic [31:0] gen_rand();
    int k, rd, rs1, rs2, sel, off;
    k   = $urandom_range(0, 4);
    rd  = $urandom_range(1, 7);
    if (rd == 2) rd = 0;
    rs1 = $urandom_range(0, 7);
    rs2 = $urandom_range(0, 7);
    sel = $urandom_range(0, 3);
    case (k)
      0: return i_type(7'h13, rd, 0, rs1, $urandom_range(0, 4095));
      1: return r_type((sel == 1) ? 32 : 0, (sel == 2) ? 7 : ((sel == 3) ? 6 : 0), rd, rs1, rs2);
      2: return i_type(7'h03, rd, 2, 2, $urandom_range(0, 127) * 4);
      3: return s_type(rs2, 2, $urandom_range(0, 127) * 4);
      default: begin
        if ($urandom_range(0, 1) == 1) rs2 = rs1;
        off = (int'($urandom_range(0, 8)) - 3) * 4;
        return b_type(rs1, rs2, off);
      end
    endcase
  endfunction

  initial begin
    logic [31:0] v, w, ea;
    tests = 0; fails = 0; ovr_data = 32'd0;
    idle();
    reset = 1;
    for (int i = 0; i < 256; i++) begin mem[i] = 32'd0; mm[i] = 32'd0; end
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    m_pc = 32'd0;

    tbl[0]  = '{32'h00500093,                32'd1, 32'd5,          32'h04};
    tbl[1]  = '{i_type(7'h13, 1, 0, 0, 7),    32'd1, 32'd7,          32'h08};
    tbl[2]  = '{i_type(7'h13, 2, 0, 0, 3),    32'd2, 32'd3,          32'h0C};
    tbl[3]  = '{r_type(32, 0, 3, 1, 2),       32'd3, 32'd4,          32'h10};
    tbl[4]  = '{r_type(0, 7, 3, 1, 2),        32'd3, 32'd3,          32'h14};
    tbl[5]  = '{r_type(0, 6, 3, 1, 2),        32'd3, 32'd7,          32'h18};
    tbl[6]  = '{r_type(0, 0, 3, 1, 2),        32'd3, 32'd10,         32'h1C};
    tbl[7]  = '{i_type(7'h13, 0, 0, 0, 9),    32'd0, 32'd0,          32'h20};
    tbl[8]  = '{b_type(1, 1, 16),             32'd1, 32'd7,          32'h30};
    tbl[9]  = '{b_type(1, 2, 16),             32'd2, 32'd3,          32'h34};
    tbl[10] = '{i_type(7'h13, 2, 0, 0, 256),  32'd2, 32'h100,        32'h38};
    tbl[11] = '{s_type(1, 2, 8),              -1,    32'd0,          32'h3C};
    tbl[12] = '{i_type(7'h03, 4, 2, 2, 8),    32'd4, 32'd7,          32'h40};
    tbl[13] = '{i_type(7'h13, 5, 0, 0, -1),   32'd5, 32'hFFFFFFFF,   32'h44};
    tbl[14] = '{r_type(0, 0, 6, 5, 5),        32'd6, 32'hFFFFFFFE,   32'h48};
    tbl[15] = '{b_type(0, 0, -8),             32'd0, 32'd0,          32'h40};
    tbl[16] = '{r_type(32, 0, 7, 0, 1),       32'd7, 32'hFFFFFFF9,   32'h44};

    #2;
    check("reset_pc", pc_out, 32'd0);
    check("reset_opcode", {25'd0, opcode}, 32'd0);
    check("reset_funct3", {29'd0, funct3}, 32'd0);
    check("reset_funct7", {25'd0, funct7}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 0;

    for (int i = 0; i <= 16; i++) begin
      exec_one(tbl[i].instr);
      check($sformatf("tbl%0d_pc", i), pc_out, tbl[i].pc);
      if (tbl[i].rg >= 0) begin
        probe(tbl[i].rg, v);
        check($sformatf("tbl%0d_x%0d", i, tbl[i].rg), v, tbl[i].val);
      end
    end

    // PC-write priority and conditional-write corners; OLDPC = PC = 0x44 after probe
    probe(0, v);
    check("probe_x0", v, 32'd0);
    idle(); PCWriteCond = 1; ALUSrcB = 2'b01; alu_ctrl = 4'b0010; clk1();
    check("cond_nonzero_hold", pc_out, 32'h44);
    idle(); PCWrite = 1; PCWriteCond = 1; ALUSrcB = 2'b01; alu_ctrl = 4'b0010; clk1();
    check("write_and_cond", pc_out, 32'h48);
    idle(); PCWriteCond = 1; ALUSrcB = 2'b01; alu_ctrl = 4'b1111; clk1();
    check("cond_zero_load", pc_out, 32'h0);
    idle();
    m_pc = 32'd0;

    exec_one(i_type(7'h13, 2, 0, 0, 512));
    for (int n = 0; n < 40; n++) begin
      w = gen_rand();
      exec_one(w);
      check($sformatf("rnd%0d_pc", n), pc_out, m_pc);
      if (w[6:0] == 7'h13 || w[6:0] == 7'h33 || w[6:0] == 7'h03) begin
        probe(int'(w[11:7]), v);
        check($sformatf("rnd%0d_x%0d", n, w[11:7]), v, m_x[w[11:7]]);
      end else if (w[6:0] == 7'h23) begin
        ea = m_x[w[19:15]] + imm_s(w);
        check($sformatf("rnd%0d_mem", n), mem[ea[9:2]], mm[ea[9:2]]);
      end
    end

    // Mid-cycle asynchronous reset with PC = 0x40
    exec_one(b_type(0, 0, int'(32'h40 - m_pc)));
    check("pc_before_reset", pc_out, 32'h40);
    #3;
    reset = 1;
    #1;
    check("async_reset_pc", pc_out, 32'd0);
    check("async_reset_ir", {funct7, 13'd0, funct3, 2'd0, opcode}, 32'd0);
    check("async_reset_addr", mem_addr, 32'd0);
    #1;
    reset = 0;
    @(posedge clk); #1;

    // Reset during write-back of addi x9 must leave no register or PC write
    mem[0] = i_type(7'h13, 9, 0, 0, 77);
    fetch();
    decode();
    idle(); ALUSrcA = 1; ALUSrcB = 2'b10; alu_ctrl = 4'b0010; clk1();
    idle(); RegWrite = 1; PCWrite = 1; ALUSrcB = 2'b01; alu_ctrl = 4'b0010;
    #2;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    idle();
    check("abandon_pc", pc_out, 32'd0);
    for (int r = 1; r < 32; r++) begin
      probe(r, v);
      check($sformatf("post_reset_x%0d", r), v, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
